// File: rtl/cp0_timer_int.sv
// cp0_timer_int
// Coprocessor-0 register block for the multi-cycle CPU. It holds Status,
// Cause, EPC, BadVAddr, Count and Compare, samples the external interrupt
// lines, runs the Count/Compare timer and raises int_req when an enabled
// interrupt is pending.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   mtc0_wen/addr/wdata : software register write (MTC0)
//   mfc0_addr/rdata     : software register read (MFC0), combinational
//   exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr : exception entry
//   eret                : return from exception, clears Status.EXL
//   hw_int              : level-sensitive external interrupt lines
//   epc_out, status_out, cause_out : register views for PC select logic
//   int_req             : interrupt request to the exception controller
module cp0_timer_int #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          TIMER_EN     = 1,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mtc0_wen,
  input  logic [4:0]            mfc0_addr,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  output logic [31:0]           mfc0_rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           epc_out,
  output logic [31:0]           status_out,
  output logic [31:0]           cause_out,
  output logic                  int_req
);

  localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
  localparam logic [4:0]    A_BADVADDR = 5'd8;
  localparam logic [4:0]    A_COUNT    = 5'd9;
  localparam logic [4:0]    A_COMPARE  = 5'd11;
  localparam logic [4:0]    A_STATUS   = 5'd12;
  localparam logic [4:0]    A_CAUSE    = 5'd13;
  localparam logic [4:0]    A_EPC      = 5'd14;

  logic [7:0]    status_im_r;
  logic          status_exl_r;
  logic          status_ie_r;
  logic          cause_bd_r;
  logic          cause_ti_r;
  logic [1:0]    cause_sw_r;
  logic [4:0]    cause_code_r;
  logic [5:0]    hw_q_r;
  logic [31:0]   epc_r;
  logic [31:0]   badvaddr_r;
  logic [31:0]   count_r;
  logic [31:0]   compare_r;
  logic [PW-1:0] presc_r;

  logic [5:0]    hw_pad_s;
  logic [7:0]    cause_ip_s;
  logic [31:0]   count_inc_s;
  logic          tick_s;
  logic          wr_count_s;
  logic          wr_compare_s;
  logic          wr_status_s;
  logic          wr_cause_s;
  logic          wr_epc_s;

  assign wr_count_s   = mtc0_wen && (mtc0_addr == A_COUNT);
  assign wr_compare_s = mtc0_wen && (mtc0_addr == A_COMPARE);
  assign wr_status_s  = mtc0_wen && (mtc0_addr == A_STATUS);
  assign wr_cause_s   = mtc0_wen && (mtc0_addr == A_CAUSE);
  assign wr_epc_s     = mtc0_wen && (mtc0_addr == A_EPC);
  assign tick_s       = (presc_r == PRESC_LAST);
  assign count_inc_s  = count_r + 32'd1;

  // Zero-extend the external lines to the six hardware IP slots.
  always_comb begin
    hw_pad_s = 6'd0;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      hw_pad_s[i] = hw_int[i];
    end
  end

  // The timer shares IP7 with the last external line.
  assign cause_ip_s = {hw_q_r[5] | cause_ti_r, hw_q_r[4:0], cause_sw_r};

  assign status_out = {16'd0, status_im_r, 6'd0, status_exl_r, status_ie_r};
  assign cause_out  = {cause_bd_r, cause_ti_r, 14'd0, cause_ip_s, 1'b0, cause_code_r, 2'b00};
  assign epc_out    = epc_r;
  assign int_req    = status_ie_r & ~status_exl_r & (|(cause_ip_s & status_im_r));

  // Status: exception entry owns EXL over eret, which owns it over MTC0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_im_r  <= STATUS_RESET[15:8];
      status_exl_r <= STATUS_RESET[1];
      status_ie_r  <= STATUS_RESET[0];
    end else begin
      if (exc_valid) begin
        status_exl_r <= 1'b1;
      end else if (eret) begin
        status_exl_r <= 1'b0;
      end else if (wr_status_s) begin
        status_exl_r <= mtc0_wdata[1];
      end
      if (wr_status_s) begin
        status_im_r <= mtc0_wdata[15:8];
        status_ie_r <= mtc0_wdata[0];
      end
    end
  end

  // Exception capture into Cause/EPC/BadVAddr plus software Cause/EPC writes.
  // A nested exception (EXL already set) keeps the original EPC and BD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_bd_r   <= 1'b0;
      cause_code_r <= 5'd0;
      cause_sw_r   <= 2'd0;
      epc_r        <= 32'd0;
      badvaddr_r   <= 32'd0;
    end else begin
      if (exc_valid) begin
        cause_code_r <= exc_code;
        if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
          badvaddr_r <= exc_badvaddr;
        end
      end
      if (exc_valid && !status_exl_r) begin
        cause_bd_r <= exc_bd;
        epc_r      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
      end else if (wr_epc_s) begin
        epc_r <= mtc0_wdata;
      end
      if (wr_cause_s) begin
        cause_sw_r <= mtc0_wdata[9:8];
      end
    end
  end

  // Count/Compare timer. TI fires only when an increment lands on Compare,
  // never on a software load of Count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r    <= {PW{1'b0}};
      count_r    <= 32'd0;
      compare_r  <= 32'd0;
      cause_ti_r <= 1'b0;
    end else begin
      if (wr_compare_s) begin
        compare_r  <= mtc0_wdata;
        cause_ti_r <= 1'b0;
      end else if ((TIMER_EN != 0) && tick_s && !wr_count_s && (count_inc_s == compare_r)) begin
        cause_ti_r <= 1'b1;
      end
      if (wr_count_s) begin
        presc_r <= {PW{1'b0}};
        count_r <= (TIMER_EN != 0) ? mtc0_wdata : 32'd0;
      end else begin
        presc_r <= tick_s ? {PW{1'b0}} : (presc_r + PW'(1));
        if ((TIMER_EN != 0) && tick_s) begin
          count_r <= count_inc_s;
        end
      end
    end
  end

  // External interrupt sample, one cycle of latency into Cause.IP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hw_q_r <= 6'd0;
    end else begin
      hw_q_r <= hw_pad_s;
    end
  end

  // MFC0 read mux; unmapped addresses read zero.
  always_comb begin
    mfc0_rdata = 32'd0;
    case (mfc0_addr)
      A_BADVADDR: mfc0_rdata = badvaddr_r;
      A_COUNT:    mfc0_rdata = count_r;
      A_COMPARE:  mfc0_rdata = compare_r;
      A_STATUS:   mfc0_rdata = status_out;
      A_CAUSE:    mfc0_rdata = cause_out;
      A_EPC:      mfc0_rdata = epc_r;
      default:    mfc0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_int.sv
module tb_cp0_timer_int;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mtc0_wen = 1'b0;
  logic [4:0]  mfc0_addr = 5'd0;
  logic [4:0]  mtc0_addr = 5'd0;
  logic [31:0] mtc0_wdata = 32'd0;
  logic [31:0] mfc0_rdata;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [31:0] exc_pc = 32'd0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badvaddr = 32'd0;
  logic        eret = 1'b0;
  logic [5:0]  hw_int = 6'd0;
  logic [31:0] epc_out, status_out, cause_out;
  logic        int_req;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp0_timer_int #(.NUM_HW_INT(6), .TIMER_EN(1), .COUNT_DIV(DIV), .STATUS_RESET(32'h0000_0001)) dut (
    .clk(clk), .reset(reset), .mtc0_wen(mtc0_wen), .mfc0_addr(mfc0_addr),
    .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata), .mfc0_rdata(mfc0_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .hw_int(hw_int), .epc_out(epc_out),
    .status_out(status_out), .cause_out(cause_out), .int_req(int_req)
  );

  // Reference model: architectural register fields plus elapsed cycles
  // since the prescaler was last cleared.
  logic        m_ie, m_exl, m_bd, m_ti;
  logic [7:0]  m_im;
  logic [5:0]  m_hw;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_count, m_cmpv;
  int          m_cyc;

  function automatic logic [31:0] f_status();
    return {16'h0, m_im, 6'h0, m_exl, m_ie};
  endfunction

  function automatic logic [7:0] f_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
  endfunction

  function automatic logic [31:0] f_cause();
    return {m_bd, m_ti, 14'h0, f_ip(), 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic f_int();
    return m_ie && !m_exl && ((f_ip() & m_im) != 8'h00);
  endfunction

  function automatic logic [31:0] f_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_cmpv;
      5'd12:   return f_status();
      5'd13:   return f_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_ie = 1'b1; m_exl = 1'b0; m_im = 8'h00; m_bd = 1'b0; m_ti = 1'b0;
    m_hw = 6'h0; m_sw = 2'h0; m_code = 5'h0; m_epc = 32'h0; m_bad = 32'h0;
    m_count = 32'h0; m_cmpv = 32'h0; m_cyc = 0;
  endtask

  // Apply one clock of architectural rules to the model using current inputs.
  task automatic model_update();
    logic wr_cnt, wr_cmp;
    wr_cnt = mtc0_wen && mtc0_addr == 5'd9;
    wr_cmp = mtc0_wen && mtc0_addr == 5'd11;
    if (exc_valid) begin
      m_code = exc_code;
      if (exc_code == 5'd4 || exc_code == 5'd5) m_bad = exc_badvaddr;
    end
    if (exc_valid && !m_exl) begin
      m_bd  = exc_bd;
      m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
    end else if (mtc0_wen && mtc0_addr == 5'd14) begin
      m_epc = mtc0_wdata;
    end
    if (exc_valid) m_exl = 1'b1;
    else if (eret) m_exl = 1'b0;
    else if (mtc0_wen && mtc0_addr == 5'd12) m_exl = mtc0_wdata[1];
    if (mtc0_wen && mtc0_addr == 5'd12) begin
      m_im = mtc0_wdata[15:8];
      m_ie = mtc0_wdata[0];
    end
    if (mtc0_wen && mtc0_addr == 5'd13) m_sw = mtc0_wdata[9:8];
    if (wr_cnt) begin
      m_count = mtc0_wdata;
      m_cyc = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (m_cyc % DIV == 0) begin
        m_count = m_count + 32'd1;
        if (m_count == m_cmpv) m_ti = 1'b1;
      end
    end
    if (wr_cmp) begin
      m_cmpv = mtc0_wdata;
      m_ti = 1'b0;
    end
    m_hw = hw_int;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_wen = 1'b1; mtc0_addr = a; mtc0_wdata = d;
    step();
    mtc0_wen = 1'b0;
  endtask

  task automatic do_exc(input logic [31:0] pc, input logic bd, input logic [4:0] code, input logic [31:0] bad);
    exc_valid = 1'b1; exc_pc = pc; exc_bd = bd; exc_code = code; exc_badvaddr = bad;
    step();
    exc_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (5) step();
    reset = 1'b1;
    m_reset();
    mfc0_addr = 5'd9;
    #1;
    n_cmp++; if (status_out !== 32'h0000_0001) begin n_err++; $display("FAIL reset_status: got %h want %h", status_out, 32'h1); end
    n_cmp++; if (cause_out !== 32'h0) begin n_err++; $display("FAIL reset_cause: got %h want 0", cause_out); end
    n_cmp++; if (epc_out !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc_out); end
    n_cmp++; if (mfc0_rdata !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", mfc0_rdata); end
    n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL reset_int_req: got %b want 0", int_req); end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    n_cmp++; if (mfc0_rdata !== 32'd0) begin n_err++; $display("FAIL count_first_edge: got %h want 0", mfc0_rdata); end
    step();
    n_cmp++; if (mfc0_rdata !== 32'd1) begin n_err++; $display("FAIL count_resume: got %h want 1", mfc0_rdata); end
  endtask

  task automatic test_timer();
    int steps;
    do_mtc0(5'd11, 32'd5);
    do_mtc0(5'd12, 32'h0000_8001);
    do_mtc0(5'd9, 32'd0);
    steps = 0;
    while (!m_ti && steps < 40) begin
      n_cmp++; if (int_req !== f_int()) begin n_err++; $display("FAIL timer_int_wait: got %b want %b", int_req, f_int()); end
      step();
      steps++;
    end
    n_cmp++; if (steps !== 10) begin n_err++; $display("FAIL timer_latency: got %0d want 10", steps); end
    mfc0_addr = 5'd9; #1;
    n_cmp++; if (mfc0_rdata !== 32'd5) begin n_err++; $display("FAIL timer_count: got %h want 5", mfc0_rdata); end
    n_cmp++; if (cause_out[30] !== 1'b1 || cause_out[15] !== 1'b1) begin n_err++; $display("FAIL timer_ti_ip7: got %h want TI,IP7 set", cause_out); end
    n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL timer_int_req: got %b want 1", int_req); end
    step();
    n_cmp++; if (cause_out[30] !== 1'b1) begin n_err++; $display("FAIL timer_ti_hold: got %b want 1", cause_out[30]); end
    do_mtc0(5'd11, 32'd20);
    n_cmp++; if (cause_out[30] !== 1'b0 || int_req !== 1'b0) begin n_err++; $display("FAIL timer_clear: got ti=%b int=%b want 0 0", cause_out[30], int_req); end
  endtask

  task automatic test_delay_slot();
    do_mtc0(5'd11, 32'h8000_0000);
    do_mtc0(5'd13, 32'h0);
    do_exc(32'h100, 1'b1, 5'd4, 32'h1003);
    mfc0_addr = 5'd8; #1;
    n_cmp++; if (epc_out !== 32'h0000_00FC) begin n_err++; $display("FAIL bd_epc: got %h want fc", epc_out); end
    n_cmp++; if (cause_out !== 32'h8000_0010) begin n_err++; $display("FAIL bd_cause: got %h want 80000010", cause_out); end
    n_cmp++; if (mfc0_rdata !== 32'h1003) begin n_err++; $display("FAIL bd_badvaddr: got %h want 1003", mfc0_rdata); end
    n_cmp++; if (status_out[1] !== 1'b1) begin n_err++; $display("FAIL bd_exl: got %b want 1", status_out[1]); end
  endtask

  task automatic test_nested();
    do_exc(32'h200, 1'b0, 5'd8, 32'hDEAD_0000);
    mfc0_addr = 5'd8; #1;
    n_cmp++; if (epc_out !== 32'h0000_00FC) begin n_err++; $display("FAIL nest_epc: got %h want fc", epc_out); end
    n_cmp++; if (cause_out[6:2] !== 5'd8 || cause_out[31] !== 1'b1) begin n_err++; $display("FAIL nest_cause: got %h want code 8 bd 1", cause_out); end
    n_cmp++; if (mfc0_rdata !== 32'h1003) begin n_err++; $display("FAIL nest_badvaddr: got %h want 1003", mfc0_rdata); end
    eret = 1'b1; step(); eret = 1'b0;
    n_cmp++; if (status_out[1] !== 1'b0) begin n_err++; $display("FAIL eret_exl: got %b want 0", status_out[1]); end
  endtask

  task automatic test_int_mask();
    do_mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001; #1;
    n_cmp++; if (int_req !== 1'b0 || cause_out[10] !== 1'b0) begin n_err++; $display("FAIL hw_latency: got int=%b ip2=%b want 0 0", int_req, cause_out[10]); end
    step();
    n_cmp++; if (int_req !== 1'b1 || cause_out[10] !== 1'b1) begin n_err++; $display("FAIL hw_int_req: got int=%b ip2=%b want 1 1", int_req, cause_out[10]); end
    do_mtc0(5'd12, 32'h0000_0403);
    n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL mask_exl: got %b want 0", int_req); end
    do_mtc0(5'd12, 32'h0000_0400);
    n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL mask_ie: got %b want 0", int_req); end
    do_mtc0(5'd12, 32'h0000_0401);
    n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL unmask: got %b want 1", int_req); end
    hw_int = 6'b0; step();
    n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL hw_release: got %b want 0", int_req); end
  endtask

  task automatic test_simul();
    mtc0_wen = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0;
    do_exc(32'h300, 1'b0, 5'd0, 32'h0);
    mtc0_wen = 1'b0;
    n_cmp++; if (status_out !== 32'h0000_0002) begin n_err++; $display("FAIL simul_status: got %h want 2", status_out); end
    n_cmp++; if (epc_out !== 32'h300) begin n_err++; $display("FAIL simul_epc: got %h want 300", epc_out); end
    eret = 1'b1; step(); eret = 1'b0;
    do_mtc0(5'd9, 32'hFFFF_FFFF);
    mfc0_addr = 5'd9; #1;
    n_cmp++; if (mfc0_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_load: got %h want ffffffff", mfc0_rdata); end
    step(); step();
    n_cmp++; if (mfc0_rdata !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h want 0", mfc0_rdata); end
    do_mtc0(5'd3, 32'h1234_5678);
    mfc0_addr = 5'd3; #1;
    n_cmp++; if (mfc0_rdata !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", mfc0_rdata); end
  endtask

  task automatic test_random();
    logic [4:0] addr_tab [8] = '{5'd3, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd20};
    logic [4:0] code_tab [4] = '{5'd0, 5'd4, 5'd5, 5'd8};
    for (int it = 0; it < 600; it++) begin
      mtc0_wen   = ($urandom_range(0, 3) == 0);
      mtc0_addr  = addr_tab[$urandom_range(0, 7)];
      mtc0_wdata = $urandom;
      if (mtc0_addr == 5'd11 && $urandom_range(0, 1) == 1) mtc0_wdata = m_count + 32'($urandom_range(1, 6));
      if (mtc0_addr == 5'd12 && $urandom_range(0, 1) == 1) mtc0_wdata = mtc0_wdata & 32'hFFFF_FFFD;
      exc_valid    = ($urandom_range(0, 11) == 0);
      exc_code     = code_tab[$urandom_range(0, 3)];
      exc_pc       = $urandom;
      exc_bd       = 1'($urandom_range(0, 1));
      exc_badvaddr = $urandom;
      eret         = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) hw_int = 6'($urandom_range(0, 63));
      mfc0_addr = 5'($urandom_range(0, 15));
      #1;
      n_cmp++; if (status_out !== f_status()) begin n_err++; $display("FAIL rnd_status it=%0d: got %h want %h", it, status_out, f_status()); end
      n_cmp++; if (cause_out !== f_cause()) begin n_err++; $display("FAIL rnd_cause it=%0d: got %h want %h", it, cause_out, f_cause()); end
      n_cmp++; if (epc_out !== m_epc) begin n_err++; $display("FAIL rnd_epc it=%0d: got %h want %h", it, epc_out, m_epc); end
      n_cmp++; if (int_req !== f_int()) begin n_err++; $display("FAIL rnd_int_req it=%0d: got %b want %b", it, int_req, f_int()); end
      n_cmp++; if (mfc0_rdata !== f_read(mfc0_addr)) begin n_err++; $display("FAIL rnd_mfc0 it=%0d addr=%0d: got %h want %h", it, mfc0_addr, mfc0_rdata, f_read(mfc0_addr)); end
      step();
    end
    mtc0_wen = 1'b0; exc_valid = 1'b0; eret = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_timer();
    test_delay_slot();
    test_nested();
    test_int_mask();
    test_simul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
